// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / branch hazard detection and a small stall FSM.
// Define HAZARD_STATS_EN to add the saturating stall_cycles counter port.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              mem_memread,
    input  logic [4:0]        mem_dest,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
`ifdef HAZARD_STATS_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic              stall
);

    // HOLD2 is a reserved encoding; it is never entered and behaves like HOLD1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD2 = 2'd1,
        HOLD1 = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;
    logic  bubble;

    logic exHit;
    logic memHit;
    logic luHaz;
    logic baHaz;
    logic blHaz;
    logic bmHaz;

    // Register $0 is hardwired, so a write to it never creates a dependency.
    assign exHit  = (ex_dest != 5'd0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
    assign memHit = (mem_dest != 5'd0) && ((mem_dest == id_rs) || (mem_dest == id_rt));

    assign luHaz = id_valid & ex_valid & ex_ctrl[1] & exHit;
    assign baHaz = id_valid & id_branch & ex_valid & ex_ctrl[0] & ~ex_ctrl[1] & exHit;
    assign blHaz = id_valid & id_branch & ex_valid & ex_ctrl[1] & exHit;
    assign bmHaz = id_valid & id_branch & mem_memread & memHit;

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        bubble    = 1'b0;
        if (reset) begin
            stateNext = IDLE;
            bubble    = 1'b1;
        end else if (flush) begin
            stateNext = IDLE;
            bubble    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (blHaz) begin
                        // Branch needs the load value in ID: wait until the load reaches WB.
                        stall     = 1'b1;
                        bubble    = 1'b1;
                        stateNext = HOLD1;
                    end else if (luHaz || baHaz || bmHaz) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
                default: begin
                    stall     = 1'b1;
                    bubble    = 1'b1;
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
        end else begin
            state <= stateNext;
            if (bubble) begin
                ex_valid   <= 1'b0;
                ex_ctrl    <= '0;
                ex_rs      <= '0;
                ex_rt      <= '0;
                ex_dest    <= '0;
                ex_rs_data <= '0;
                ex_rt_data <= '0;
                ex_imm     <= '0;
                ex_pc4     <= '0;
            end else begin
                ex_valid   <= id_valid;
                ex_ctrl    <= id_valid ? id_ctrl : '0;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_dest    <= id_dest;
                ex_rs_data <= id_rs_data;
                ex_rt_data <= id_rt_data;
                ex_imm     <= id_imm;
                ex_pc4     <= id_pc4;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    assign stall_cycles = stallCount;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued as each ID step is driven
// and compared one posedge later; stall is checked mid-cycle.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 12;
    localparam int VEC_W  = 1 + CTRL_W + 15 + 4 * DATA_W;

    localparam logic [CTRL_W-1:0] CTRL_LW  = 12'h083;
    localparam logic [CTRL_W-1:0] CTRL_ALU = 12'h401;
    localparam logic [CTRL_W-1:0] CTRL_BR  = 12'h800;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_dest;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_branch;
    logic              flush;
    logic              mem_memread;
    logic [4:0]        mem_dest;
    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dest;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall;
`ifdef HAZARD_STATS_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       expCnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [VEC_W-1:0] expQ[$];
    logic [VEC_W-1:0] exObs;

    assign exObs = {ex_valid, ex_ctrl, ex_rs, ex_rt, ex_dest, ex_rs_data, ex_rt_data, ex_imm, ex_pc4};

    id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_ctrl(id_ctrl), .id_branch(id_branch), .flush(flush),
        .mem_memread(mem_memread), .mem_dest(mem_dest),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_ctrl(ex_ctrl),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic [CTRL_W-1:0] ctrl, input logic br);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_dest    = dest;
        id_ctrl    = ctrl;
        id_branch  = br;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        id_pc4     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endtask

    task automatic setMem(input logic rd, input logic [4:0] dest);
        mem_memread = rd;
        mem_dest    = dest;
    endtask

    // One clock: check stall mid-cycle, queue the expected EX contents, compare after the edge.
    task automatic step(input string tag, input logic expStall, input logic expLoad);
        logic [VEC_W-1:0] expVec;
        logic [VEC_W-1:0] gotExp;
        @(negedge clk);
        checks++;
        assert (stall === expStall) else begin
            failures++;
            $error("FAIL %s_stall observed=%0b expected=%0b", tag, stall, expStall);
        end
        if (expLoad)
            expVec = {id_valid, (id_valid ? id_ctrl : {CTRL_W{1'b0}}), id_rs, id_rt, id_dest,
                      id_rs_data, id_rt_data, id_imm, id_pc4};
        else
            expVec = '0;
        expQ.push_back(expVec);
`ifdef HAZARD_STATS_EN
        if (reset) expCnt = 16'd0;
        else if (expStall && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
`endif
        @(posedge clk);
        #1;
        gotExp = expQ.pop_front();
        checks++;
        assert (exObs === gotExp) else begin
            failures++;
            $error("FAIL %s_ex observed=%h expected=%h", tag, exObs, gotExp);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        assert (stall_cycles === expCnt) else begin
            failures++;
            $error("FAIL %s_cnt observed=%0d expected=%0d", tag, stall_cycles, expCnt);
        end
`endif
    endtask

    initial begin
`ifdef HAZARD_STATS_EN
        expCnt = 16'd0;
`endif
        flush = 1'b0;
        reset = 1'b1;
        setMem(1'b1, 5'd7);
        setId(1'b1, 5'd7, 5'd7, 5'd3, CTRL_LW, 1'b1);
        step("reset0", 1'b0, 1'b0);
        setId(1'b1, 5'd9, 5'd2, 5'd9, CTRL_ALU, 1'b0);
        step("reset1", 1'b0, 1'b0);
        reset = 1'b0;

        // Load-use: lw $8 then add reading $8.
        setMem(1'b0, 5'd0);
        setId(1'b1, 5'd1, 5'd8, 5'd8, CTRL_LW, 1'b0);
        step("lu_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd8, 5'd2, 5'd3, CTRL_ALU, 1'b0);
        step("lu_stall", 1'b1, 1'b0);
        step("lu_go", 1'b0, 1'b1);

        // Branch after load: two stall cycles, beq enters EX on the third edge.
        setId(1'b1, 5'd1, 5'd9, 5'd9, CTRL_LW, 1'b0);
        step("bl_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd4, 5'd9, 5'd0, CTRL_BR, 1'b1);
        step("bl_stall1", 1'b1, 1'b0);
        setMem(1'b1, 5'd9);
        step("bl_stall2", 1'b1, 1'b0);
        setMem(1'b0, 5'd0);
        step("bl_go", 1'b0, 1'b1);

        // Branch after ALU op.
        setId(1'b1, 5'd2, 5'd3, 5'd5, CTRL_ALU, 1'b0);
        step("ba_alu", 1'b0, 1'b1);
        setId(1'b1, 5'd5, 5'd6, 5'd0, CTRL_BR, 1'b1);
        step("ba_stall", 1'b1, 1'b0);
        setMem(1'b0, 5'd5);
        step("ba_go", 1'b0, 1'b1);

        // Branch reading a load sitting in EX/MEM.
        setMem(1'b0, 5'd0);
        setId(1'b1, 5'd1, 5'd10, 5'd10, CTRL_LW, 1'b0);
        step("bm_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd11, 5'd7, 5'd12, CTRL_ALU, 1'b0);
        step("bm_alu", 1'b0, 1'b1);
        setMem(1'b1, 5'd10);
        setId(1'b1, 5'd10, 5'd0, 5'd0, CTRL_BR, 1'b1);
        step("bm_stall", 1'b1, 1'b0);
        setMem(1'b0, 5'd12);
        step("bm_go", 1'b0, 1'b1);

        // Register $0 never creates a hazard.
        setMem(1'b0, 5'd0);
        setId(1'b1, 5'd1, 5'd0, 5'd0, CTRL_LW, 1'b0);
        step("z_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd0, 5'd0, 5'd0, CTRL_BR, 1'b1);
        step("z_ex", 1'b0, 1'b1);
        setMem(1'b1, 5'd0);
        setId(1'b1, 5'd0, 5'd0, 5'd0, CTRL_BR, 1'b1);
        step("z_mem", 1'b0, 1'b1);

        // Invalid ID slot: no stall, loads with valid and control cleared.
        setMem(1'b0, 5'd0);
        setId(1'b1, 5'd1, 5'd13, 5'd13, CTRL_LW, 1'b0);
        step("inv_lw", 1'b0, 1'b1);
        setId(1'b0, 5'd13, 5'd13, 5'd4, 12'hFFF, 1'b1);
        step("inv_slot", 1'b0, 1'b1);

        // Flush while in HOLD1, then prove the FSM is back in IDLE.
        setId(1'b1, 5'd1, 5'd14, 5'd14, CTRL_LW, 1'b0);
        step("fl_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd3, 5'd14, 5'd0, CTRL_BR, 1'b1);
        step("fl_stall", 1'b1, 1'b0);
        flush = 1'b1;
        setMem(1'b1, 5'd14);
        step("fl_hold1", 1'b0, 1'b0);
        flush = 1'b0;
        setId(1'b1, 5'd14, 5'd2, 5'd6, CTRL_ALU, 1'b0);
        step("fl_idle", 1'b0, 1'b1);

        // Flush beats a load-use hazard in IDLE.
        setMem(1'b0, 5'd0);
        setId(1'b1, 5'd1, 5'd15, 5'd15, CTRL_LW, 1'b0);
        step("fl2_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd15, 5'd1, 5'd7, CTRL_ALU, 1'b0);
        flush = 1'b1;
        step("fl2_kill", 1'b0, 1'b0);
        flush = 1'b0;
        step("fl2_go", 1'b0, 1'b1);

        // Reset in the middle of a two-cycle stall.
        setId(1'b1, 5'd1, 5'd16, 5'd16, CTRL_LW, 1'b0);
        step("rs_lw", 1'b0, 1'b1);
        setId(1'b1, 5'd16, 5'd2, 5'd0, CTRL_BR, 1'b1);
        step("rs_stall", 1'b1, 1'b0);
        reset = 1'b1;
        step("rs_reset", 1'b0, 1'b0);
        reset = 1'b0;
        setId(1'b1, 5'd16, 5'd1, 5'd8, CTRL_ALU, 1'b0);
        step("rs_go", 1'b0, 1'b1);

`ifdef HAZARD_STATS_EN
        // Back-to-back stalls, then saturation near the top of the counter.
        setMem(1'b1, 5'd20);
        setId(1'b1, 5'd20, 5'd21, 5'd0, CTRL_BR, 1'b1);
        for (int i = 0; i < 300; i++) step("stats_run", 1'b1, 1'b0);
        force dut.stallCount = 16'hFFFD;
        #1;
        release dut.stallCount;
        expCnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) step("stats_sat", 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
